// File: rtl/mul_hilo_stage_pkg.sv
// Shared constants and state encoding for the multiplier HI/LO stage.
// Reused by the multiplier and the datapath top level.
package mul_hilo_stage_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 32;
    localparam int unsigned DEFAULT_MUL_CYCLES = 2;
    localparam int unsigned CNT_W              = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_hilo_stage.sv
// Holds operands stable for the external combinational multiplier, captures
// the product into HI/LO and services direct mthi/mtlo-style writes.
module mul_hilo_stage
    import mul_hilo_stage_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned MUL_CYCLES = DEFAULT_MUL_CYCLES
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   x_in,
    input  logic [WIDTH-1:0]   y_in,
    output logic [WIDTH-1:0]   mul_x,
    output logic [WIDTH-1:0]   mul_y,
    input  logic [2*WIDTH-1:0] mul_rslt,
    input  logic               hi_wr,
    input  logic               lo_wr,
    input  logic [WIDTH-1:0]   bus_in,
    output logic [WIDTH-1:0]   hi_out,
    output logic [WIDTH-1:0]   lo_out,
    output logic               busy,
    output logic               done
);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] mul_x_nxt, mul_y_nxt, hi_nxt, lo_nxt;

    // State and datapath registers
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state  <= IDLE;
            cnt    <= '0;
            mul_x  <= '0;
            mul_y  <= '0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            mul_x  <= mul_x_nxt;
            mul_y  <= mul_y_nxt;
            hi_out <= hi_nxt;
            lo_out <= lo_nxt;
        end
    end

    // Next-state: DONE accepts start/writes like IDLE; WAIT ignores both
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mul_x_nxt = mul_x;
        mul_y_nxt = mul_y;
        hi_nxt    = hi_out;
        lo_nxt    = lo_out;
        case (state)
            IDLE, DONE: begin
                if (hi_wr) hi_nxt = bus_in;
                if (lo_wr) lo_nxt = bus_in;
                if (start) begin
                    mul_x_nxt = x_in;
                    mul_y_nxt = y_in;
                    cnt_nxt   = CNT_W'(MUL_CYCLES - 1);
                    state_nxt = WAIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    hi_nxt    = mul_rslt[2*WIDTH-1:WIDTH];
                    lo_nxt    = mul_rslt[WIDTH-1:0];
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == WAIT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mul_hilo_stage.sv
// Randomized bench for mul_hilo_stage against a timeline model of issue/land
// events; also models a multiplier that is wrong until its settle window ends.
module tb_mul_hilo_stage;

    localparam int unsigned W  = 32;
    localparam int unsigned MC = 2;

    logic          clock;
    logic          clear_n;
    logic          start;
    logic [W-1:0]  x_in, y_in;
    logic [W-1:0]  mul_x, mul_y;
    logic [2*W-1:0] mul_rslt;
    logic          hi_wr, lo_wr;
    logic [W-1:0]  bus_in;
    logic [W-1:0]  hi_out, lo_out;
    logic          busy, done;

    mul_hilo_stage #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .start    (start),
        .x_in     (x_in),
        .y_in     (y_in),
        .mul_x    (mul_x),
        .mul_y    (mul_y),
        .mul_rslt (mul_rslt),
        .hi_wr    (hi_wr),
        .lo_wr    (lo_wr),
        .bus_in   (bus_in),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] prod64(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Multiplier model: output is corrupted until operands have been stable long enough
    logic [W-1:0] prev_x, prev_y;
    int           stable_edges;
    logic         op_changed, rslt_valid;

    always @(posedge clock) begin
        if (op_changed) stable_edges <= 0;
        else if (stable_edges < 1000) stable_edges <= stable_edges + 1;
        prev_x <= mul_x;
        prev_y <= mul_y;
    end

    always_comb begin
        op_changed = (mul_x != prev_x) || (mul_y != prev_y);
        rslt_valid = (MC < 2) || (!op_changed && (stable_edges + 2 >= int'(MC)));
        mul_rslt   = rslt_valid ? prod64(mul_x, mul_y)
                                : prod64(mul_x, mul_y) ^ 64'hA5A5_5A5A_C3C3_3C3C;
    end

    // Reference model: pending operation lands MC edges after the issuing edge
    int           cyc;
    bit           m_pend, m_done;
    int           m_due;
    logic [W-1:0] m_x, m_y, m_hi, m_lo;
    int           errors, checks;

    task automatic model_reset();
        m_pend = 0; m_done = 0; m_due = 0;
        m_x = '0; m_y = '0; m_hi = '0; m_lo = '0;
    endtask

    task automatic model_edge();
        logic [63:0] p;
        cyc++;
        if (!clear_n) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (m_pend) begin
            if (cyc == m_due) begin
                p      = prod64(m_x, m_y);
                m_hi   = p[63:32];
                m_lo   = p[31:0];
                m_pend = 0;
                m_done = 1;
            end
        end else begin
            if (hi_wr) m_hi = bus_in;
            if (lo_wr) m_lo = bus_in;
            if (start) begin
                m_x    = x_in;
                m_y    = y_in;
                m_pend = 1;
                m_due  = cyc + int'(MC);
            end
        end
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        check_eq("busy",   64'(busy),   64'(m_pend));
        check_eq("done",   64'(done),   64'(m_done));
        check_eq("hi_out", 64'(hi_out), 64'(m_hi));
        check_eq("lo_out", 64'(lo_out), 64'(m_lo));
        check_eq("mul_x",  64'(mul_x),  64'(m_x));
        check_eq("mul_y",  64'(mul_y),  64'(m_y));
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic set_idle();
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; x_in = x; y_in = y;
    endtask

    // Asynchronous reset pulse held across one rising edge
    task automatic reset_pulse();
        clear_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        cycle();
        clear_n = 1'b1;
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'(0);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        errors = 0; checks = 0; cyc = 0;
        model_reset();
        clear_n = 1'b0;
        set_idle();
        x_in = '0; y_in = '0; bus_in = '0;
        repeat (2) cycle();
        clear_n = 1'b1;
        cycle();

        // 7 * -3
        issue(32'd7, 32'hFFFF_FFFD); cycle(); set_idle();
        repeat (4) cycle();
        check_eq("hi_7x-3", 64'(hi_out), 64'h0000_0000_FFFF_FFFF);
        check_eq("lo_7x-3", 64'(lo_out), 64'h0000_0000_FFFF_FFEB);

        // Extreme operands
        issue(32'h8000_0000, 32'h8000_0000); cycle(); set_idle();
        repeat (3) cycle();
        check_eq("hi_min_sq", 64'(hi_out), 64'h0000_0000_4000_0000);
        check_eq("lo_min_sq", 64'(lo_out), 64'h0);
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF); cycle(); set_idle();
        repeat (3) cycle();
        check_eq("hi_max_neg", 64'(hi_out), 64'h0000_0000_FFFF_FFFF);
        check_eq("lo_max_neg", 64'(lo_out), 64'h0000_0000_8000_0001);

        // Start during WAIT is ignored
        issue(32'd5, 32'd6); cycle();
        issue(32'd9, 32'd9); cycle(); set_idle();
        repeat (3) cycle();
        check_eq("lo_5x6", 64'(lo_out), 64'd30);

        // Direct writes in IDLE, then dropped during WAIT
        hi_wr = 1'b1; bus_in = 32'hDEAD_BEEF; cycle(); set_idle();
        lo_wr = 1'b1; bus_in = 32'h1234_5678; cycle(); set_idle();
        check_eq("hi_direct", 64'(hi_out), 64'h0000_0000_DEAD_BEEF);
        check_eq("lo_direct", 64'(lo_out), 64'h0000_0000_1234_5678);
        issue(32'd11, 32'd3); cycle(); set_idle();
        hi_wr = 1'b1; lo_wr = 1'b1; bus_in = 32'hAAAA_5555; cycle(); set_idle();
        repeat (3) cycle();
        check_eq("lo_after_drop", 64'(lo_out), 64'd33);

        // Reset in the middle of WAIT, then a fresh full window
        issue(32'd3, 32'd4); cycle(); set_idle();
        reset_pulse();
        issue(32'd3, 32'd4); cycle(); set_idle();
        repeat (3) cycle();
        check_eq("lo_3x4", 64'(lo_out), 64'd12);

        // Back-to-back issue from DONE
        issue(32'd3, 32'd5); cycle(); set_idle();
        repeat (int'(MC)) cycle();
        check_eq("done_first", 64'(done), 64'd1);
        issue(32'd2, 32'd2); cycle(); set_idle();
        check_eq("busy_b2b", 64'(busy), 64'd1);
        repeat (int'(MC)) cycle();
        check_eq("done_second", 64'(done), 64'd1);
        check_eq("lo_2x2", 64'(lo_out), 64'd4);
        repeat (2) cycle();

        // Random traffic
        repeat (600) begin
            start  = ($urandom_range(0, 2) == 0);
            hi_wr  = ($urandom_range(0, 4) == 0);
            lo_wr  = ($urandom_range(0, 4) == 0);
            bus_in = 32'($urandom);
            x_in   = rand_operand();
            y_in   = rand_operand();
            if ($urandom_range(0, 99) == 0) begin
                set_idle();
                reset_pulse();
            end else begin
                cycle();
            end
        end
        set_idle();
        repeat (4) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_hilo_stage.md
Name: mul_hilo_stage

Overview:
- Sequential stage directly downstream of the CPU's combinational 32x32 signed Booth multiplier.
- Registers the operands and holds them stable on the multiplier inputs for a fixed multi-cycle window.
- Captures the 64-bit product into the architectural HI/LO register pair and signals completion with a one-cycle done pulse.
- Also services direct HI/LO writes from the CPU bus, for mthi/mtlo-style moves.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- MUL_CYCLES, 2, number of clock cycles the combinational multiplier is given to settle; legal range 1..15.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- clear_n  in  1  asynchronous active-low reset.
- start  in  1  request a multiply using x_in/y_in.
- x_in  in  WIDTH  multiplicand, signed.
- y_in  in  WIDTH  multiplier, signed.
- mul_x  out  WIDTH  registered multiplicand, driven to the multiplier.
- mul_y  out  WIDTH  registered multiplier, driven to the multiplier.
- mul_rslt  in  2*WIDTH  product returned by the multiplier.
- hi_wr  in  1  load bus_in into HI.
- lo_wr  in  1  load bus_in into LO.
- bus_in  in  WIDTH  data for direct HI/LO writes.
- hi_out  out  WIDTH  HI register, upper product half.
- lo_out  out  WIDTH  LO register, lower product half.
- busy  out  1  high while a multiply is in flight (state WAIT).
- done  out  1  one-cycle pulse: HI/LO were just loaded with a product.

Behaviour:
- Reset: clear_n low asynchronously forces state IDLE and clears the following to 0:
  - mul_x, mul_y, hi_out, lo_out, the wait counter, busy and done.
- States and transitions:
  - IDLE: on start=1, load mul_x<=x_in, mul_y<=y_in, cnt<=MUL_CYCLES-1, go to WAIT.
  - WAIT: if cnt!=0, cnt<=cnt-1 and stay in WAIT; if cnt==0, hi_out<=mul_rslt[2W-1:W], lo_out<=mul_rslt[W-1:0], go to DONE.
  - DONE: done=1 for this cycle only. Behaves exactly like IDLE for start (accepts it and goes to WAIT); otherwise goes to IDLE.
- Latency: for start sampled at edge T, HI/LO are updated at edge T+MUL_CYCLES, and done is high for the cycle following that edge.
  - Back-to-back issue from DONE gives one result every MUL_CYCLES+1 cycles.
- busy is combinational: state==WAIT. done is combinational: state==DONE.
- mul_x and mul_y change only on an accepted start. They hold their value through WAIT, DONE and IDLE, so multiplier inputs never glitch mid-window.
- start while in WAIT is ignored: no queuing, no abort, operands unchanged.
- Direct writes:
  - hi_wr/lo_wr are honoured in IDLE and DONE; both may be asserted together, loading the same bus_in into both.
  - In WAIT they are dropped silently, so the pending product is not corrupted.
  - In the cycle of an accepted start (IDLE/DONE), the direct write is also performed; the product later overwrites it.
- Arithmetic: no sign or width manipulation here. The product is taken verbatim from mul_rslt, which is treated as the full two's-complement 2*WIDTH signed product.
- Reset mid-WAIT aborts the operation: no done pulse, HI/LO read 0, and the next start begins a fresh full window.
- With MUL_CYCLES=1, WAIT lasts exactly one cycle (cnt loads 0).

Decomposition:
- Shared package/include holds:
  - the state encodings (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - the default WIDTH and MUL_CYCLES constants, reused by the multiplier and the datapath top level.
- The counter and the HI/LO registers are trivial and stay inline; the block is one module with no sub-module.
- The multiplier is instantiated beside this block by the datapath top level, not inside it.

Test Plan:
- Reset, then start with x=7, y=-3 (MUL_CYCLES=2) -> busy high 2 cycles; done pulses at T+2; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- x=0x80000000, y=0x80000000 -> HI=0x40000000, LO=0x00000000. Then x=0x7FFFFFFF, y=-1 -> HI=0xFFFFFFFF, LO=0x80000001.
- Start x=5, y=6, then pulse start with x=9, y=9 during WAIT -> mul_x/mul_y stay 5/6; result HI=0, LO=30; exactly one done pulse.
- In IDLE, hi_wr=1 with bus_in=0xDEADBEEF, then lo_wr=1 with bus_in=0x12345678 -> hi_out/lo_out show those values next cycle. Repeat hi_wr during WAIT -> HI unchanged until the product lands.
- Drive clear_n low for one cycle midway through WAIT of 3*4 -> all outputs 0 immediately, no done. A new start of 3*4 then yields LO=12 after the full MUL_CYCLES window.
- Assert start during DONE with x=2, y=2 -> new WAIT begins with no IDLE cycle; second done arrives 3 cycles after the first; LO=4.
